// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, the
// stage-register control bundle with its canned settings, and hazard priority.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MDBUSY = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_clr;
    logic idex_en;
    logic idex_clr;
    logic idex_bb;
    logic exmem_en;
    logic exmem_clr;
    logic memwb_en;
    logic memwb_bb;
  } ctrl_t;

  // Bit order follows the struct: pc, ifid en/clr, idex en/clr/bb, exmem en/clr, memwb en/bb
  localparam ctrl_t CTRL_DEFAULT = ctrl_t'(10'b1_10_100_10_10);
  localparam ctrl_t CTRL_LOADUSE = ctrl_t'(10'b0_00_101_10_10);
  localparam ctrl_t CTRL_BRANCH  = ctrl_t'(10'b1_11_110_10_10);
  localparam ctrl_t CTRL_EXC     = ctrl_t'(10'b1_11_110_11_10);
  localparam ctrl_t CTRL_FREEZE  = ctrl_t'(10'b0_00_000_00_11);
  localparam ctrl_t CTRL_IDLE    = ctrl_t'(10'b0_00_000_00_00);
  localparam ctrl_t CTRL_RESET   = ctrl_t'(10'b0_01_010_01_00);

  typedef enum logic [2:0] {
    HZ_NONE    = 3'd0,
    HZ_LOADUSE = 3'd1,
    HZ_BRANCH  = 3'd2,
    HZ_MULDIV  = 3'd3,
    HZ_EXC     = 3'd4,
    HZ_HALT    = 3'd5
  } hazard_e;

  function automatic hazard_e hazard_pick(input logic halt, input logic exc,
                                          input logic muldiv, input logic branch,
                                          input logic loaduse);
    if (halt)         return HZ_HALT;
    else if (exc)     return HZ_EXC;
    else if (muldiv)  return HZ_MULDIV;
    else if (branch)  return HZ_BRANCH;
    else if (loaduse) return HZ_LOADUSE;
    else              return HZ_NONE;
  endfunction

endpackage

// File: rtl/md_timer.sv
// Loadable down-counter for mul/div freezes; last flags the final busy cycle.
module md_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              count <= '0;
    else if (clear)          count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - W'(1);
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: Mealy controls from
// registered state plus live hazard inputs, with performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wbreg,
  input  logic             ex_branch_taken,
  input  logic             ex_muldiv_start,
  input  logic             ex_is_div,
  input  logic             exc_req,
  input  logic             wb_syscall_halt,
  input  logic             go,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_en,
  output logic             idex_clr,
  output logic             idex_bb,
  output logic             exmem_en,
  output logic             exmem_clr,
  output logic             memwb_en,
  output logic             memwb_bb,
  output logic             halted,
  output logic             md_busy,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int MAXC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int TW   = $clog2(MAXC);

  state_e  state_q, state_d;
  hazard_e hz;
  ctrl_t   ctrl;
  logic    go_q, md_ack, ack_d;
  logic    t_load, t_clear, t_last, flush;
  logic    load_use;
  logic [TW-1:0] t_val;

  assign load_use = ex_memread && (ex_wbreg != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_wbreg)) ||
                     (id_uses_rt && (id_rt == ex_wbreg)));

  assign hz    = hazard_pick(wb_syscall_halt, exc_req, ex_muldiv_start && !md_ack,
                             ex_branch_taken, load_use);
  assign t_val = ex_is_div ? TW'(DIV_CYCLES - 1) : TW'(MUL_CYCLES - 1);

  md_timer #(.W(TW)) u_md_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .clear    (t_clear),
    .load_val (t_val),
    .last     (t_last)
  );

  always_comb begin
    ctrl    = CTRL_DEFAULT;
    state_d = state_q;
    t_load  = 1'b0;
    t_clear = 1'b0;
    ack_d   = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        unique case (hz)
          HZ_HALT:    begin ctrl = CTRL_FREEZE; state_d = ST_HALT; end
          HZ_EXC:     begin ctrl = CTRL_EXC; flush = 1'b1; end
          HZ_MULDIV:  begin ctrl = CTRL_FREEZE; t_load = 1'b1; state_d = ST_MDBUSY; end
          HZ_BRANCH:  begin ctrl = CTRL_BRANCH; flush = 1'b1; end
          HZ_LOADUSE: ctrl = CTRL_LOADUSE;
          default:    ctrl = CTRL_DEFAULT;
        endcase
      end
      ST_MDBUSY: begin
        if (exc_req) begin
          ctrl    = CTRL_EXC;
          flush   = 1'b1;
          t_clear = 1'b1;
          state_d = ST_RUN;
        end else begin
          ctrl = CTRL_FREEZE;
          // md_ack masks the start level still held by the finishing instruction
          if (t_last) begin
            state_d = ST_RUN;
            ack_d   = 1'b1;
          end
        end
      end
      ST_HALT: begin
        ctrl = CTRL_IDLE;
        if (go && !go_q) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (!rst_n) ctrl = CTRL_RESET;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      go_q      <= 1'b0;
      md_ack    <= 1'b0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= go;
      md_ack  <= ack_d;
      if (state_q != ST_HALT) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (!ctrl.pc_en) stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign pc_en     = ctrl.pc_en;
  assign ifid_en   = ctrl.ifid_en;
  assign ifid_clr  = ctrl.ifid_clr;
  assign idex_en   = ctrl.idex_en;
  assign idex_clr  = ctrl.idex_clr;
  assign idex_bb   = ctrl.idex_bb;
  assign exmem_en  = ctrl.exmem_en;
  assign exmem_clr = ctrl.exmem_clr;
  assign memwb_en  = ctrl.memwb_en;
  assign memwb_bb  = ctrl.memwb_bb;
  assign halted    = (state_q == ST_HALT);
  assign md_busy   = (state_q == ST_MDBUSY);

endmodule
